// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
// Round-robin front end for one shared 2-stage pipelined adder.
// Each cycle at most one requester is granted. Its operands are muxed onto
// the adder inputs, and its ID rides a two-deep tag pipe alongside the adder.
// The ID then comes back out with the adder's registered sum.
//
// Handshake: requester i transfers when req_valid[i] & req_ready[i] are both
// high at a rising edge. req_ready is one-hot, depends combinationally on
// req_valid, and is never raised to a requester that is not valid. The
// response side has no backpressure: rsp_valid is a one-cycle pulse per op.

module adder_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int DW    = 7,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_en,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       add_a,
  output logic [DW-1:0]       add_b,
  input  logic [DW:0]         add_sum,
  output logic                rsp_valid,
  output logic [ID_W-1:0]     rsp_id,
  output logic [DW:0]         rsp_data,
  output logic [CNT_W-1:0]    op_cnt
);

  // Round-robin pointer: index of the most recently granted requester.
  logic [ID_W-1:0] ptr;

  // Arbitration result for the current cycle.
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            handshake;

  // Tag pipe, aligned with the adder's operand and sum registers.
  logic            stage1_valid;
  logic [ID_W-1:0] stage1_id;
  logic            stage2_valid;
  logic [ID_W-1:0] stage2_id;

  // Scan ptr+1, ptr+2, ... (mod N_REQ) for the first valid requester.
  // Grants are suppressed while issue is disabled. They are also suppressed
  // while reset is held, so no grant is shown during reset.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!grant_found && issue_en && rst_n && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // Drive the one-hot grant and mux the granted operands onto the adder.
  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
      add_a = req_a[int'(grant_idx)*DW +: DW];
      add_b = req_b[int'(grant_idx)*DW +: DW];
    end
  end

  // A transfer happens only where valid and ready coincide.
  assign handshake = |(req_valid & req_ready);

  // Pointer advances to the granted requester; reset points at the last one
  // so that requester 0 is the first candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= ID_W'(N_REQ - 1);
    end else if (handshake) begin
      ptr <= grant_idx;
    end
  end

  // Tag pipe: stage1 is loaded with the grant, and stage2 follows stage1.
  // Stage2 then lines up with the adder's registered sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_valid <= 1'b0;
      stage1_id    <= '0;
      stage2_valid <= 1'b0;
      stage2_id    <= '0;
    end else begin
      stage1_valid <= handshake;
      stage1_id    <= handshake ? grant_idx : '0;
      stage2_valid <= stage1_valid;
      stage2_id    <= stage1_id;
    end
  end

  // Count handshakes since reset, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (handshake && (op_cnt != {CNT_W{1'b1}})) begin
      op_cnt <= op_cnt + 1'b1;
    end
  end

  assign rsp_valid = stage2_valid;
  assign rsp_id    = stage2_id;
  assign rsp_data  = add_sum;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler
// Directed bench for adder_rr_scheduler with a behavioural 2-stage adder.
// A second instance with a 4-bit counter shares the same stimulus, so the
// counter's saturation can be checked.

module tb_adder_rr_scheduler;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int DW    = 7;

  // Operand set used whenever all requesters are valid:
  // req i: a = 10*(i+1), b = i+1  -> sums 11, 22, 33, 44
  localparam logic [27:0] A_ALL = {7'd40, 7'd30, 7'd20, 7'd10};
  localparam logic [27:0] B_ALL = {7'd4,  7'd3,  7'd2,  7'd1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                issue_en;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       add_a;
  logic [DW-1:0]       add_b;
  logic [DW:0]         add_sum;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [DW:0]         rsp_data;
  logic [15:0]         op_cnt;

  logic [N_REQ-1:0]    sat_ready;
  logic [DW-1:0]       sat_add_a;
  logic [DW-1:0]       sat_add_b;
  logic                sat_rsp_valid;
  logic [ID_W-1:0]     sat_rsp_id;
  logic [DW:0]         sat_rsp_data;
  logic [3:0]          sat_op_cnt;

  adder_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .DW(DW), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .op_cnt(op_cnt)
  );

  adder_rr_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .DW(DW), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(sat_ready),
    .add_a(sat_add_a), .add_b(sat_add_b), .add_sum(add_sum),
    .rsp_valid(sat_rsp_valid), .rsp_id(sat_rsp_id), .rsp_data(sat_rsp_data),
    .op_cnt(sat_op_cnt)
  );

  // Behavioural shared adder: operand registers, then a sum register.
  logic [DW-1:0] op_a_q, op_b_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      add_sum <= '0;
    end else begin
      op_a_q  <= add_a;
      op_b_q  <= add_b;
      add_sum <= {1'b0, op_a_q} + {1'b0, op_b_q};
    end
  end

  // ---------------- scoreboard ----------------
  // Each entry holds {id[1:0], sum[7:0]}.
  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every presented response must match the head of the queue.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: got id=%0d data=%0d, expected no response (t=%0t)",
                 rsp_id, rsp_data, $time);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("rsp_id", int'(rsp_id), int'(e[9:8]));
        check("rsp_data", int'(rsp_data), int'(e[7:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Drive one cycle's inputs and check the grant at the negedge. If a
  // handshake is expected, queue the expected response. Then advance past
  // the handshake edge.
  task automatic step(input logic en, input logic [3:0] v,
                      input logic [27:0] a, input logic [27:0] b,
                      input logic [3:0] exp_rdy, input logic [7:0] exp_sum);
    logic [1:0] id;
    issue_en  = en;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    check("req_ready", int'(req_ready), int'(exp_rdy));
    if (exp_rdy != 4'b0) begin
      id = 2'd0;
      for (int i = 0; i < N_REQ; i++) if (exp_rdy[i]) id = 2'(i);
      exp_q.push_back({id, exp_sum});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'b0000, 28'd0, 28'd0, 4'b0000, 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    issue_en  = 1'b1;
    req_valid = 4'b1111;
    req_a     = A_ALL;
    req_b     = B_ALL;

    // Reset held with every request valid: nothing granted, nothing out.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", int'(req_ready), 0);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_id", int'(rsp_id), 0);
    check("reset_op_cnt", int'(op_cnt), 0);
    check("reset_add_a", int'(add_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four valid for 8 cycles: order 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b0001, 8'd11);
      step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b0010, 8'd22);
      step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b0100, 8'd33);
      step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b1000, 8'd44);
    end
    idle(3);
    check("op_cnt_after_8", int'(op_cnt), 8);

    // Single op: requester 1, 100 + 27 = 127.
    step(1'b1, 4'b0010, {7'd0, 7'd0, 7'd100, 7'd0}, {7'd0, 7'd0, 7'd27, 7'd0},
         4'b0010, 8'd127);
    idle(3);

    // Max operands on requester 3: 127 + 127 = 254.
    step(1'b1, 4'b1000, {7'd127, 7'd0, 7'd0, 7'd0}, {7'd127, 7'd0, 7'd0, 7'd0},
         4'b1000, 8'd254);
    // Requester 2 alone for three cycles: 50 + 60 = 110 each time.
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'b0100, {7'd0, 7'd50, 7'd0, 7'd0}, {7'd0, 7'd60, 7'd0, 7'd0},
           4'b0100, 8'd110);
    idle(3);

    // Requests present but issue disabled: no handshake, no state change.
    step(1'b0, 4'b1111, A_ALL, B_ALL, 4'b0000, 8'd0);
    step(1'b0, 4'b1111, A_ALL, B_ALL, 4'b0000, 8'd0);

    // The pointer is at 2, so grants go to 3 and then wrap to 0.
    step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b1000, 8'd44);
    step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b0001, 8'd11);
    // Issue drops mid-burst: the two ops still return, and nothing new starts.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, A_ALL, B_ALL, 4'b0000, 8'd0);
    // Re-enable: resumes at ptr+1 = 1.
    step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b0010, 8'd22);
    idle(3);
    check("op_cnt_after_16", int'(op_cnt), 16);
    check("sat_op_cnt_16_ops", int'(sat_op_cnt), 15);

    // Grant requester 0, then reset before the op reaches the output.
    step(1'b1, 4'b0001, A_ALL, B_ALL, 4'b0001, 8'd11);
    exp_q.delete();
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_rsp_valid", int'(rsp_valid), 0);
    check("midreset_op_cnt", int'(op_cnt), 0);
    check("midreset_req_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // After reset, 20 ops: 5 rounds starting at requester 0.
    for (int r = 0; r < 5; r++) begin
      step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b0001, 8'd11);
      step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b0010, 8'd22);
      step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b0100, 8'd33);
      step(1'b1, 4'b1111, A_ALL, B_ALL, 4'b1000, 8'd44);
    end
    idle(3);
    check("op_cnt_after_20", int'(op_cnt), 20);
    check("sat_op_cnt_20_ops", int'(sat_op_cnt), 15);

    // Every queued response must have come back.
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
